// File: rtl/kbd_line_buffer_pkg.sv
// Shared constants and encodings for the keyboard line buffer.
package kbd_pkg;

  localparam logic [6:0] ASCII_BS        = 7'h08;
  localparam logic [6:0] ASCII_CR        = 7'h0D;
  localparam logic [6:0] ASCII_SPACE     = 7'h20;
  localparam logic [6:0] ASCII_PRINT_MIN = 7'h20;
  localparam logic [6:0] ASCII_PRINT_MAX = 7'h7E;

  typedef enum logic {
    EDIT = 1'b0,
    DONE = 1'b1
  } state_t;

  // Decoded action for one accepted keyboard event.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_PUT,
    ACT_WRAP,
    ACT_BS,
    ACT_BS_UP,
    ACT_CR_NEXT,
    ACT_CR_DONE
  } act_t;

endpackage

// File: rtl/kbd_line_buffer_if.sv
// Keyboard-side inputs and display-side outputs of the line buffer.
interface kbd_line_buffer_if #(
  parameter int CHAR_W    = 7,
  parameter int LINE_LEN  = 11,
  parameter int NUM_LINES = 2
);
  localparam int TOT    = NUM_LINES * LINE_LEN;
  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int COL_W  = $clog2(LINE_LEN + 1);

  logic                    New;
  logic [CHAR_W-1:0]       Char;
  logic                    Clear;
  logic [TOT*CHAR_W-1:0]   String;
  logic [LINE_W-1:0]       CursorLine;
  logic [COL_W-1:0]        CursorCol;
  logic                    Change;
  logic                    Full;
  logic                    Complete;

  modport master (
    output New, Char, Clear,
    input  String, CursorLine, CursorCol, Change, Full, Complete
  );

  modport slave (
    input  New, Char, Clear,
    output String, CursorLine, CursorCol, Change, Full, Complete
  );
endinterface

// File: rtl/kbd_line_buffer_strobe_rise.sv
// One-bit rising-edge detector; a level held high yields a single-cycle rise.
module strobe_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) d_reg <= 1'b0;
    else        d_reg <= d;
  end

  assign rise = d & ~d_reg;
endmodule

// File: rtl/kbd_line_buffer.sv
// Keyboard text buffer: collects characters into NUM_LINES x LINE_LEN cells
// with backspace, Enter and Clear, and exposes the cells as a flat bus.
module kbd_line_buffer
  import kbd_pkg::*;
#(
  parameter int                CHAR_W    = 7,
  parameter int                LINE_LEN  = 11,
  parameter int                NUM_LINES = 2,
  parameter logic [CHAR_W-1:0] BS_CODE   = CHAR_W'(ASCII_BS),
  parameter logic [CHAR_W-1:0] CR_CODE   = CHAR_W'(ASCII_CR),
  parameter logic [CHAR_W-1:0] PAD_CODE  = CHAR_W'(ASCII_SPACE)
) (
  input logic              Clock,
  input logic              Reset,
  kbd_line_buffer_if.slave bus
);
  localparam int TOT    = NUM_LINES * LINE_LEN;
  localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int COL_W  = $clog2(LINE_LEN + 1);
  localparam int IDX_W  = $clog2(TOT + 1);

  state_t            state_reg;
  logic [LINE_W-1:0] line_reg;
  logic [COL_W-1:0]  col_reg;
  logic              change_reg;
  logic              complete_reg;

  logic              ev;
  logic              is_print;
  logic              last_line;
  logic              at_eol;
  logic [IDX_W-1:0]  cur_idx;
  act_t              act;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [CHAR_W-1:0] wr_data;

  strobe_rise u_new_rise (
    .clk   (Clock),
    .rst_n (Reset),
    .d     (bus.New),
    .rise  (ev)
  );

  assign is_print  = (bus.Char >= CHAR_W'(ASCII_PRINT_MIN)) && (bus.Char <= CHAR_W'(ASCII_PRINT_MAX));
  assign last_line = (line_reg == LINE_W'(NUM_LINES - 1));
  assign at_eol    = (col_reg == COL_W'(LINE_LEN));
  // At end of line this equals the first cell of the next line, so a wrap writes here too.
  assign cur_idx   = IDX_W'(line_reg) * IDX_W'(LINE_LEN) + IDX_W'(col_reg);

  always_comb begin
    act = ACT_NONE;
    if (ev && state_reg == EDIT) begin
      if (is_print) begin
        if (!at_eol)         act = ACT_PUT;
        else if (!last_line) act = ACT_WRAP;
      end else if (bus.Char == BS_CODE) begin
        if (col_reg != '0)       act = ACT_BS;
        else if (line_reg != '0) act = ACT_BS_UP;
      end else if (bus.Char == CR_CODE) begin
        act = last_line ? ACT_CR_DONE : ACT_CR_NEXT;
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_data = bus.Char;
    case (act)
      ACT_PUT, ACT_WRAP: wr_en = 1'b1;
      ACT_BS, ACT_BS_UP: begin
        wr_en   = 1'b1;
        wr_idx  = cur_idx - IDX_W'(1);
        wr_data = PAD_CODE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg    <= EDIT;
      line_reg     <= '0;
      col_reg      <= '0;
      change_reg   <= 1'b0;
      complete_reg <= 1'b0;
    end else if (bus.Clear) begin
      state_reg    <= EDIT;
      line_reg     <= '0;
      col_reg      <= '0;
      change_reg   <= 1'b1;
      complete_reg <= 1'b0;
    end else begin
      change_reg <= (act != ACT_NONE);
      case (act)
        ACT_PUT:   col_reg <= col_reg + COL_W'(1);
        ACT_WRAP: begin
          line_reg <= line_reg + LINE_W'(1);
          col_reg  <= COL_W'(1);
        end
        ACT_BS:    col_reg <= col_reg - COL_W'(1);
        ACT_BS_UP: begin
          line_reg <= line_reg - LINE_W'(1);
          col_reg  <= COL_W'(LINE_LEN - 1);
        end
        ACT_CR_NEXT: begin
          line_reg <= line_reg + LINE_W'(1);
          col_reg  <= '0;
        end
        ACT_CR_DONE: begin
          state_reg    <= DONE;
          complete_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Cell 0 sits in the most significant slice of the flat bus.
  for (genvar gi = 0; gi < TOT; gi++) begin : g_cell
    logic [CHAR_W-1:0] cell_reg;

    always_ff @(posedge Clock) begin
      if (!Reset || bus.Clear)                    cell_reg <= PAD_CODE;
      else if (wr_en && wr_idx == IDX_W'(gi))     cell_reg <= wr_data;
    end

    assign bus.String[(TOT-gi)*CHAR_W-1 -: CHAR_W] = cell_reg;
  end

  assign bus.CursorLine = line_reg;
  assign bus.CursorCol  = col_reg;
  assign bus.Change     = change_reg;
  assign bus.Complete   = complete_reg;
  assign bus.Full       = last_line && at_eol;

endmodule

// File: tb/tb_kbd_line_buffer.sv
// Table-driven bench for kbd_line_buffer with a Change-driven scoreboard.
module tb_kbd_line_buffer;
  localparam int CHAR_W    = 7;
  localparam int LINE_LEN  = 11;
  localparam int NUM_LINES = 2;
  localparam int TOT       = NUM_LINES * LINE_LEN;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kbd_line_buffer_if #(.CHAR_W(CHAR_W), .LINE_LEN(LINE_LEN), .NUM_LINES(NUM_LINES)) bus ();

  kbd_line_buffer #(.CHAR_W(CHAR_W), .LINE_LEN(LINE_LEN), .NUM_LINES(NUM_LINES)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [TOT*CHAR_W-1:0] str;
    int line;
    int col;
    int cyc;
  } exp_t;

  typedef struct {
    logic [6:0] ch;
    int rep;
    int hold;
    int line;
    int col;
    bit full;
    bit comp;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl[18];

  logic [6:0] m_cells [NUM_LINES][LINE_LEN];
  int m_line, m_col;
  bit m_done;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TOT*CHAR_W-1:0] model_flat();
    logic [TOT*CHAR_W-1:0] s;
    s = '0;
    for (int r = 0; r < NUM_LINES; r++)
      for (int c = 0; c < LINE_LEN; c++)
        s[(TOT - (r*LINE_LEN + c))*CHAR_W-1 -: CHAR_W] = m_cells[r][c];
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NUM_LINES; r++)
      for (int c = 0; c < LINE_LEN; c++)
        m_cells[r][c] = 7'h20;
    m_line = 0;
    m_col  = 0;
    m_done = 0;
  endtask

  // Expected effect of one keyboard event; pushes to the scoreboard if Change should pulse.
  task automatic model_event(input logic [6:0] ch, input bit clr, input int at);
    bit chg;
    exp_t e;
    chg = 0;
    if (clr) begin
      model_clear();
      chg = 1;
    end else if (!m_done) begin
      if (ch >= 7'h20 && ch <= 7'h7E) begin
        if (m_col < LINE_LEN) begin
          m_cells[m_line][m_col] = ch;
          m_col++;
          chg = 1;
        end else if (m_line < NUM_LINES - 1) begin
          m_line++;
          m_cells[m_line][0] = ch;
          m_col = 1;
          chg = 1;
        end
      end else if (ch == 7'h08) begin
        if (m_col > 0) begin
          m_col--;
          m_cells[m_line][m_col] = 7'h20;
          chg = 1;
        end else if (m_line > 0) begin
          m_line--;
          m_col = LINE_LEN - 1;
          m_cells[m_line][m_col] = 7'h20;
          chg = 1;
        end
      end else if (ch == 7'h0D) begin
        if (m_line < NUM_LINES - 1) begin
          m_line++;
          m_col = 0;
        end else begin
          m_done = 1;
        end
        chg = 1;
      end
    end
    if (chg) begin
      e.str  = model_flat();
      e.line = m_line;
      e.col  = m_col;
      e.cyc  = at + 1;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive(input logic [6:0] ch, input int hold, input bit clr);
    @(posedge clk); #1;
    bus.Char  = ch;
    bus.New   = 1'b1;
    bus.Clear = clr;
    model_event(ch, clr, cyc);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      bus.Clear = 1'b0;
    end
    @(posedge clk); #1;
    bus.New   = 1'b0;
    bus.Clear = 1'b0;
  endtask

  task automatic check_state(input string tag, input int line, input int col, input bit full, input bit comp);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_line"}, bus.CursorLine, line);
    check({tag, "_col"}, bus.CursorCol, col);
    check({tag, "_full"}, bus.Full, full);
    check({tag, "_complete"}, bus.Complete, comp);
    check({tag, "_pending_change"}, sb_q.size(), 0);
  endtask

  // Scoreboard: every Change pulse must match the oldest expected update.
  always @(negedge clk) begin
    if (bus.Change === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_change", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_string", bus.String, mon_e.str);
        check("sb_line", bus.CursorLine, mon_e.line);
        check("sb_col", bus.CursorCol, mon_e.col);
        check("sb_change_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    tbl[0]  = '{7'h41, 1, 1, 0, 1, 0, 0};   // 'A'
    tbl[1]  = '{7'h42, 1, 1, 0, 2, 0, 0};   // 'B'
    tbl[2]  = '{7'h43, 1, 5, 0, 3, 0, 0};   // 'C' held 5 cycles
    tbl[3]  = '{7'h08, 1, 1, 0, 2, 0, 0};   // BS
    tbl[4]  = '{7'h07, 1, 1, 0, 2, 0, 0};   // control code ignored
    tbl[5]  = '{7'h7F, 1, 1, 0, 2, 0, 0};   // DEL ignored
    tbl[6]  = '{7'h44, 9, 1, 0, 11, 0, 0};  // fill line 0
    tbl[7]  = '{7'h5A, 1, 1, 1, 1, 0, 0};   // wrap to line 1
    tbl[8]  = '{7'h08, 2, 1, 0, 10, 0, 0};  // BS back across the line
    tbl[9]  = '{7'h45, 1, 1, 0, 11, 0, 0};
    tbl[10] = '{7'h0D, 1, 1, 1, 0, 0, 0};   // Enter to next line
    tbl[11] = '{7'h46, 11, 1, 1, 11, 1, 0}; // fill last line
    tbl[12] = '{7'h47, 1, 1, 1, 11, 1, 0};  // dropped
    tbl[13] = '{7'h08, 1, 1, 1, 10, 0, 0};
    tbl[14] = '{7'h48, 1, 1, 1, 11, 1, 0};
    tbl[15] = '{7'h0D, 1, 1, 1, 11, 1, 1};  // Enter on last line
    tbl[16] = '{7'h49, 1, 1, 1, 11, 1, 1};  // ignored in DONE
    tbl[17] = '{7'h08, 1, 1, 1, 11, 1, 1};  // ignored in DONE

    rst_n     = 1'b0;
    bus.New   = 1'b0;
    bus.Char  = '0;
    bus.Clear = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_string", bus.String, model_flat());
    check("reset_line", bus.CursorLine, 0);
    check("reset_col", bus.CursorCol, 0);
    check("reset_full", bus.Full, 0);
    check("reset_complete", bus.Complete, 0);
    check("reset_change", bus.Change, 0);

    for (int r = 0; r < 18; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) drive(tbl[r].ch, tbl[r].hold, 1'b0);
      $display("row %0d ch=%02h x%0d -> line=%0d col=%0d full=%0d complete=%0d",
               r, tbl[r].ch, tbl[r].rep, bus.CursorLine, bus.CursorCol, bus.Full, bus.Complete);
      check_state($sformatf("row%0d", r), tbl[r].line, tbl[r].col, tbl[r].full, tbl[r].comp);
    end

    // Clear and a character in the same cycle while DONE: Clear wins.
    drive(7'h4B, 1, 1'b1);
    $display("clear+new in DONE -> line=%0d col=%0d complete=%0d", bus.CursorLine, bus.CursorCol, bus.Complete);
    check_state("clear_new", 0, 0, 0, 0);
    check("clear_string", bus.String, model_flat());

    // Backspace at the home position does nothing.
    drive(7'h08, 1, 1'b0);
    $display("bs at home -> line=%0d col=%0d", bus.CursorLine, bus.CursorCol);
    check_state("bs_home", 0, 0, 0, 0);

    // Enter from an empty first line, then one character.
    drive(7'h0D, 1, 1'b0);
    $display("cr on line 0 -> line=%0d col=%0d", bus.CursorLine, bus.CursorCol);
    check_state("cr_line0", 1, 0, 0, 0);
    drive(7'h51, 1, 1'b0);
    $display("char on line 1 -> line=%0d col=%0d", bus.CursorLine, bus.CursorCol);
    check_state("char_line1", 1, 1, 0, 0);

    // Reset in the middle of editing: no Change, everything back to spaces.
    @(posedge clk); #1 rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    $display("mid reset -> line=%0d col=%0d change=%0d", bus.CursorLine, bus.CursorCol, bus.Change);
    check("midrst_string", bus.String, model_flat());
    check("midrst_change", bus.Change, 0);
    check_state("midrst", 0, 0, 0, 0);

    drive(7'h52, 1, 1'b0);
    $display("char after reset -> line=%0d col=%0d", bus.CursorLine, bus.CursorCol);
    check_state("after_rst", 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
